conv3x3_sched: RTL and testbench

Sequencer that computes one 3x3 convolution output per accepted window on a single `pmul` 3-tap PE chain. It loads a 3x3 window and runs it through the chain one kernel row at a time. For each row it holds the chain's data and weight inputs stable until `pm_psum_vld` returns, then accumulates the three row sums. It sits between the window/line-buffer stage and the `pmul` instance, and owns the 9-entry kernel weight bank.

---
 rtl/cnn_pkg.sv | 25 ++
 rtl/conv3x3_sched_wgt_bank.sv | 61 ++++++
 rtl/conv3x3_sched.sv | 174 +++++++++++++++++
 tb/tb_conv3x3_sched.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// cnn_pkg
// Shared definitions for the convolution sequencer slice: the scheduler FSM
// state encoding, the tap/window sizes and the row-major window index helper
// (k = 3*row + col) used both for the weight bank and the window register.
package cnn_pkg;

  localparam int NTAP = 3;
  localparam int NWIN = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

  // Row-major index of element (row, col) in a 3x3 window. The result is
  // 4 bits wide so that callers can detect row 3 (past the window) as >= NWIN.
  function automatic logic [3:0] win_idx(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] r4;
    r4 = {2'b00, row};
    return (r4 << 1) + r4 + {2'b00, col};
  endfunction

endpackage

// File: rtl/conv3x3_sched_wgt_bank.sv
// wgt_bank
// 9-entry kernel weight register file for the 3x3 convolution sequencer.
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset (clears all weights)
//   we_i, addr_i,      write strobe / index / value; a write only lands when
//   wdata_i            idle_i is high and addr_i is a valid index (0..8)
//   idle_i             high while the sequencer is in IDLE
//   row_i              kernel row selected for the three read ports
//   rd0_o..rd2_o       weights (row_i, 0..2), combinational
module wgt_bank
  import cnn_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic             idle_i,
  input  logic [3:0]       addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [1:0]       row_i,
  output logic [WIDTH-1:0] rd0_o,
  output logic [WIDTH-1:0] rd1_o,
  output logic [WIDTH-1:0] rd2_o
);

  logic [WIDTH-1:0] wgt_q [NWIN];
  logic [WIDTH-1:0] rd    [NTAP];
  logic [3:0]       rd_idx[NTAP];
  logic             wr_en;

  assign wr_en = we_i && idle_i && (addr_i < 4'(NWIN));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NWIN; i++) wgt_q[i] <= '0;
    end else if (wr_en) begin
      wgt_q[addr_i] <= wdata_i;
    end
  end

  // Read ports forward a write landing in the same cycle. The sequencer
  // latches row 0 weights on the same edge that accepts a window, so a write
  // issued alongside the accept must already be visible to that first row.
  always_comb begin
    for (int c = 0; c < NTAP; c++) begin
      rd_idx[c] = win_idx(row_i, 2'(c));
      rd[c]     = '0;
      if (wr_en && (addr_i == rd_idx[c])) begin
        rd[c] = wdata_i;
      end else if (rd_idx[c] < 4'(NWIN)) begin
        rd[c] = wgt_q[rd_idx[c]];
      end
    end
  end

  assign rd0_o = rd[0];
  assign rd1_o = rd[1];
  assign rd2_o = rd[2];

endmodule

// File: rtl/conv3x3_sched.sv
// conv3x3_sched
// Runs one accepted 3x3 window through a single 3-tap pmul chain, one kernel
// row at a time, and accumulates the three row partial sums (mod 2^WIDTH).
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   cfg_we_i/addr_i/wdata_i       kernel weight write (IDLE only, index 0..8)
//   win_valid_i/win_ready_o       window handshake, win_data_i row-major
//   out_valid_o/out_ready_i       result handshake, out_data_o result
//   pm_update_o                   one-cycle launch of a row into pmul
//   pm_data*_o, pm_weight*_o      pmul taps, held from ISSUE until WAIT exits
//   pm_psum_i, pm_psum_vld_i      row partial sum returned by pmul
//   err_timeout_o                 one-cycle pulse when a WAIT is abandoned
module conv3x3_sched
  import cnn_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               cfg_we_i,
  input  logic [3:0]         cfg_addr_i,
  input  logic [WIDTH-1:0]   cfg_wdata_i,
  input  logic               win_valid_i,
  output logic               win_ready_o,
  input  logic [9*WIDTH-1:0] win_data_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [WIDTH-1:0]   out_data_o,
  output logic               pm_update_o,
  output logic [WIDTH-1:0]   pm_data0_o,
  output logic [WIDTH-1:0]   pm_data1_o,
  output logic [WIDTH-1:0]   pm_data2_o,
  output logic [WIDTH-1:0]   pm_weight0_o,
  output logic [WIDTH-1:0]   pm_weight1_o,
  output logic [WIDTH-1:0]   pm_weight2_o,
  input  logic [WIDTH-1:0]   pm_psum_i,
  input  logic               pm_psum_vld_i,
  output logic               err_timeout_o
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  state_e             state_q;
  logic [1:0]         row_q;
  logic [WIDTH-1:0]   acc_q;
  logic [TW-1:0]      tmo_q;
  logic [9*WIDTH-1:0] win_q;
  logic [WIDTH-1:0]   dat_q [NTAP];
  logic [WIDTH-1:0]   wgt_q [NTAP];
  logic [WIDTH-1:0]   out_data_q;
  logic               err_q;

  logic [1:0]         load_row_d;
  logic [9*WIDTH-1:0] load_src_d;
  logic [WIDTH-1:0]   load_dat_d [NTAP];
  logic [WIDTH-1:0]   load_wgt_d [NTAP];
  logic [3:0]         load_idx_d [NTAP];
  logic [WIDTH-1:0]   acc_d;
  logic               idle;

  assign idle = (state_q == ST_IDLE);

  // The tap registers are reloaded on two kinds of edge: the accept edge
  // (row 0, taken straight from win_data_i since win_q is being written on
  // the same edge) and the edge leaving WAIT for the next row (from win_q).
  assign load_row_d = idle ? 2'd0 : (row_q + 2'd1);
  assign load_src_d = idle ? win_data_i : win_q;
  assign acc_d      = acc_q + pm_psum_i;

  always_comb begin
    for (int c = 0; c < NTAP; c++) begin
      load_idx_d[c] = win_idx(load_row_d, 2'(c));
      load_dat_d[c] = '0;
      if (load_idx_d[c] < 4'(NWIN)) begin
        load_dat_d[c] = load_src_d[int'(load_idx_d[c])*WIDTH +: WIDTH];
      end
    end
  end

  wgt_bank #(
    .WIDTH (WIDTH)
  ) u_wgt_bank (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .we_i    (cfg_we_i),
    .idle_i  (idle),
    .addr_i  (cfg_addr_i),
    .wdata_i (cfg_wdata_i),
    .row_i   (load_row_d),
    .rd0_o   (load_wgt_d[0]),
    .rd1_o   (load_wgt_d[1]),
    .rd2_o   (load_wgt_d[2])
  );

  // Scheduler FSM. The WAIT timeout counter counts completed WAIT cycles
  // without a psum; reaching TIMEOUT-1 on a cycle that still has no psum
  // means WAIT has lasted TIMEOUT cycles, so the window is abandoned.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      row_q      <= '0;
      acc_q      <= '0;
      tmo_q      <= '0;
      win_q      <= '0;
      out_data_q <= '0;
      err_q      <= 1'b0;
      for (int c = 0; c < NTAP; c++) begin
        dat_q[c] <= '0;
        wgt_q[c] <= '0;
      end
    end else begin
      err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (win_valid_i) begin
            win_q   <= win_data_i;
            acc_q   <= '0;
            row_q   <= '0;
            for (int c = 0; c < NTAP; c++) begin
              dat_q[c] <= load_dat_d[c];
              wgt_q[c] <= load_wgt_d[c];
            end
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          tmo_q   <= '0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (pm_psum_vld_i) begin
            acc_q <= acc_d;
            if (row_q == 2'd2) begin
              out_data_q <= acc_d;
              state_q    <= ST_OUT;
            end else begin
              row_q <= row_q + 2'd1;
              for (int c = 0; c < NTAP; c++) begin
                dat_q[c] <= load_dat_d[c];
                wgt_q[c] <= load_wgt_d[c];
              end
              state_q <= ST_ISSUE;
            end
          end else if (tmo_q == TW'(TIMEOUT - 1)) begin
            err_q   <= 1'b1;
            acc_q   <= '0;
            state_q <= ST_IDLE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        ST_OUT: begin
          if (out_ready_i) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign win_ready_o   = (state_q == ST_IDLE);
  assign pm_update_o   = (state_q == ST_ISSUE);
  assign out_valid_o   = (state_q == ST_OUT);
  assign out_data_o    = out_data_q;
  assign err_timeout_o = err_q;

  assign pm_data0_o    = dat_q[0];
  assign pm_data1_o    = dat_q[1];
  assign pm_data2_o    = dat_q[2];
  assign pm_weight0_o  = wgt_q[0];
  assign pm_weight1_o  = wgt_q[1];
  assign pm_weight2_o  = wgt_q[2];

endmodule

// File: tb/tb_conv3x3_sched.sv
// tb_conv3x3_sched
// Directed bench for conv3x3_sched with a small 3-tap pmul stand-in of
// latency 3. Cycle numbers are counted with the accept edge as edge 0, so
// the first cycle after the accept is cycle 1. Inputs change and outputs are
// sampled on the falling edge.
module tb_conv3x3_sched;

  localparam int W   = 8;
  localparam int LAT = 3;

  logic           clk = 1'b0;
  logic           rstN;
  logic           cfgWe;
  logic [3:0]     cfgAddr;
  logic [W-1:0]   cfgWdata;
  logic           winValid;
  logic           winReady;
  logic [9*W-1:0] winData;
  logic           outValid;
  logic           outReady;
  logic [W-1:0]   outData;
  logic           pmUpdate;
  logic [W-1:0]   pmData0, pmData1, pmData2;
  logic [W-1:0]   pmWeight0, pmWeight1, pmWeight2;
  logic [W-1:0]   pmPsum;
  logic           pmPsumVld;
  logic           errTimeout;

  int errors = 0;
  int checks = 0;

  logic           modelEn = 1'b1;
  logic [LAT-1:0] pipeV;
  logic [W-1:0]   pipeP [LAT];

  int outCyc;
  int updCyc [$];
  int updD0  [$];
  int updD2  [$];

  always #5 clk = ~clk;

  conv3x3_sched #(.WIDTH(W), .TIMEOUT(64)) dut (
    .clk_i         (clk),
    .rst_ni        (rstN),
    .cfg_we_i      (cfgWe),
    .cfg_addr_i    (cfgAddr),
    .cfg_wdata_i   (cfgWdata),
    .win_valid_i   (winValid),
    .win_ready_o   (winReady),
    .win_data_i    (winData),
    .out_valid_o   (outValid),
    .out_ready_i   (outReady),
    .out_data_o    (outData),
    .pm_update_o   (pmUpdate),
    .pm_data0_o    (pmData0),
    .pm_data1_o    (pmData1),
    .pm_data2_o    (pmData2),
    .pm_weight0_o  (pmWeight0),
    .pm_weight1_o  (pmWeight1),
    .pm_weight2_o  (pmWeight2),
    .pm_psum_i     (pmPsum),
    .pm_psum_vld_i (pmPsumVld),
    .err_timeout_o (errTimeout)
  );

  // pmul stand-in: samples the taps when update is high and returns the
  // 3-tap dot product (mod 2^W) LAT cycles later. Shares the DUT reset.
  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      pipeV <= '0;
      for (int i = 0; i < LAT; i++) pipeP[i] <= '0;
    end else begin
      pipeV    <= {pipeV[LAT-2:0], pmUpdate};
      pipeP[0] <= W'(pmData0 * pmWeight0 + pmData1 * pmWeight1 + pmData2 * pmWeight2);
      for (int i = 1; i < LAT; i++) pipeP[i] <= pipeP[i-1];
    end
  end

  assign pmPsumVld = modelEn & pipeV[LAT-1];
  assign pmPsum    = pipeP[LAT-1];

  function automatic logic [9*W-1:0] packWin(input int base, input int step);
    logic [9*W-1:0] v;
    v = '0;
    for (int k = 0; k < 9; k++) v[k*W +: W] = W'(base + step * k);
    return v;
  endfunction

  task automatic writeWeight(input logic [3:0] addr, input logic [W-1:0] val);
    cfgWe    = 1'b1;
    cfgAddr  = addr;
    cfgWdata = val;
    @(negedge clk);
    cfgWe    = 1'b0;
  endtask

  task automatic writeAllWeights(input logic [W-1:0] val);
    for (int k = 0; k < 9; k++) writeWeight(4'(k), val);
  endtask

  // Offers one window and returns on the falling edge of cycle 1.
  task automatic applyStimulus(input logic [9*W-1:0] win);
    winValid = 1'b1;
    winData  = win;
    @(negedge clk);
    winValid = 1'b0;
  endtask

  // Records pm_update cycles and tap values until out_valid shows up or the
  // budget runs out (outCyc stays -1 in that case).
  task automatic runToOut(input int startCyc, input int budget);
    int n;
    n      = startCyc;
    outCyc = -1;
    updCyc.delete();
    updD0.delete();
    updD2.delete();
    for (int k = 0; k < budget; k++) begin
      if (pmUpdate) begin
        updCyc.push_back(n);
        updD0.push_back(int'(pmData0));
        updD2.push_back(int'(pmData2));
      end
      if (outValid) begin
        outCyc = n;
        break;
      end
      @(negedge clk);
      n++;
    end
  endtask

  task automatic consumeOut();
    outReady = 1'b1;
    @(negedge clk);
    outReady = 1'b0;
  endtask

  task automatic test_reset();
    rstN     = 1'b0;
    cfgWe    = 1'b0;
    cfgAddr  = '0;
    cfgWdata = '0;
    winValid = 1'b0;
    winData  = '0;
    outReady = 1'b0;
    #12;
    checks++; if (winReady !== 1'b1) begin errors++; $display("[TB] FAIL reset_win_ready: got %b expected 1", winReady); end
    checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", outValid); end
    checks++; if (pmUpdate !== 1'b0) begin errors++; $display("[TB] FAIL reset_pm_update: got %b expected 0", pmUpdate); end
    checks++; if (errTimeout !== 1'b0) begin errors++; $display("[TB] FAIL reset_err_timeout: got %b expected 0", errTimeout); end
    checks++; if (outData !== 8'd0) begin errors++; $display("[TB] FAIL reset_out_data: got %0d expected 0", outData); end
    checks++; if (pmData0 !== 8'd0 || pmWeight2 !== 8'd0) begin errors++; $display("[TB] FAIL reset_taps: got d0=%0d w2=%0d expected 0/0", pmData0, pmWeight2); end
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    checks++; if (winReady !== 1'b1) begin errors++; $display("[TB] FAIL release_win_ready: got %b expected 1", winReady); end
  endtask

  task automatic test_basic();
    writeAllWeights(8'd1);
    checks++; if (winReady !== 1'b1) begin errors++; $display("[TB] FAIL basic_ready: got %b expected 1", winReady); end
    applyStimulus(packWin(1, 1));
    runToOut(1, 60);
    checks++; if (updCyc.size() != 3) begin errors++; $display("[TB] FAIL basic_update_count: got %0d expected 3", updCyc.size()); end
    if (updCyc.size() == 3) begin
      checks++; if (updCyc[0] != 1 || updCyc[1] != 5 || updCyc[2] != 9) begin errors++; $display("[TB] FAIL basic_update_cycles: got %0d,%0d,%0d expected 1,5,9", updCyc[0], updCyc[1], updCyc[2]); end
      checks++; if (updD0[0] != 1 || updD0[1] != 4 || updD0[2] != 7) begin errors++; $display("[TB] FAIL basic_tap0_rows: got %0d,%0d,%0d expected 1,4,7", updD0[0], updD0[1], updD0[2]); end
      checks++; if (updD2[0] != 3 || updD2[1] != 6 || updD2[2] != 9) begin errors++; $display("[TB] FAIL basic_tap2_rows: got %0d,%0d,%0d expected 3,6,9", updD2[0], updD2[1], updD2[2]); end
    end
    checks++; if (outCyc != 13) begin errors++; $display("[TB] FAIL basic_out_cycle: got %0d expected 13", outCyc); end
    checks++; if (outData !== 8'd45) begin errors++; $display("[TB] FAIL basic_out_data: got %0d expected 45", outData); end
    consumeOut();
    checks++; if (outValid !== 1'b0 || winReady !== 1'b1) begin errors++; $display("[TB] FAIL basic_after_handshake: got valid=%b ready=%b expected 0/1", outValid, winReady); end
  endtask

  task automatic test_wrap();
    writeAllWeights(8'd16);
    applyStimulus(packWin(2, 0));
    runToOut(1, 60);
    checks++; if (outCyc != 13) begin errors++; $display("[TB] FAIL wrap_out_cycle: got %0d expected 13", outCyc); end
    checks++; if (outData !== 8'd32) begin errors++; $display("[TB] FAIL wrap_out_data: got %0d expected 32", outData); end
    consumeOut();
  endtask

  task automatic test_back_to_back();
    applyStimulus(packWin(1, 0));
    runToOut(1, 60);
    checks++; if (outData !== 8'd144) begin errors++; $display("[TB] FAIL stall_first_data: got %0d expected 144", outData); end
    winValid = 1'b1;
    winData  = packWin(3, 0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++; if (outData !== 8'd144 || outValid !== 1'b1) begin errors++; $display("[TB] FAIL stall_hold_%0d: got data=%0d valid=%b expected 144/1", k, outData, outValid); end
      checks++; if (winReady !== 1'b0) begin errors++; $display("[TB] FAIL stall_ready_%0d: got %b expected 0", k, winReady); end
    end
    outReady = 1'b1;
    @(negedge clk);
    outReady = 1'b0;
    checks++; if (winReady !== 1'b1 || outValid !== 1'b0) begin errors++; $display("[TB] FAIL stall_release: got ready=%b valid=%b expected 1/0", winReady, outValid); end
    @(negedge clk);
    winValid = 1'b0;
    checks++; if (pmUpdate !== 1'b1) begin errors++; $display("[TB] FAIL stall_next_accept: got update=%b expected 1", pmUpdate); end
    runToOut(1, 60);
    checks++; if (outCyc != 13) begin errors++; $display("[TB] FAIL stall_second_cycle: got %0d expected 13", outCyc); end
    checks++; if (outData !== 8'd176) begin errors++; $display("[TB] FAIL stall_second_data: got %0d expected 176", outData); end
    consumeOut();
  endtask

  task automatic test_dropped_writes();
    writeWeight(4'd12, 8'd7);
    applyStimulus(packWin(1, 0));
    @(negedge clk);
    cfgWe    = 1'b1;
    cfgAddr  = 4'd0;
    cfgWdata = 8'd5;
    @(negedge clk);
    cfgWe    = 1'b0;
    runToOut(3, 60);
    checks++; if (outCyc != 13) begin errors++; $display("[TB] FAIL drop_out_cycle: got %0d expected 13", outCyc); end
    checks++; if (outData !== 8'd144) begin errors++; $display("[TB] FAIL drop_first_data: got %0d expected 144", outData); end
    consumeOut();
    applyStimulus(packWin(1, 0));
    checks++; if (pmWeight0 !== 8'd16) begin errors++; $display("[TB] FAIL drop_weight0: got %0d expected 16", pmWeight0); end
    runToOut(1, 60);
    checks++; if (outData !== 8'd144) begin errors++; $display("[TB] FAIL drop_next_data: got %0d expected 144", outData); end
    consumeOut();
  endtask

  task automatic test_write_on_accept();
    cfgWe    = 1'b1;
    cfgAddr  = 4'd0;
    cfgWdata = 8'd2;
    applyStimulus(packWin(1, 0));
    cfgWe    = 1'b0;
    checks++; if (pmWeight0 !== 8'd2) begin errors++; $display("[TB] FAIL accept_write_tap: got %0d expected 2", pmWeight0); end
    runToOut(1, 60);
    checks++; if (outData !== 8'd130) begin errors++; $display("[TB] FAIL accept_write_data: got %0d expected 130", outData); end
    consumeOut();
  endtask

  task automatic test_timeout();
    int errCnt;
    int errCyc;
    int sawOut;
    errCnt  = 0;
    errCyc  = -1;
    sawOut  = 0;
    modelEn = 1'b0;
    applyStimulus(packWin(1, 0));
    for (int n = 1; n <= 100; n++) begin
      if (errTimeout) begin
        errCnt++;
        if (errCyc < 0) errCyc = n;
      end
      if (outValid) sawOut++;
      @(negedge clk);
    end
    checks++; if (errCnt != 1) begin errors++; $display("[TB] FAIL timeout_pulses: got %0d expected 1", errCnt); end
    checks++; if (errCyc != 66) begin errors++; $display("[TB] FAIL timeout_cycle: got %0d expected 66", errCyc); end
    checks++; if (sawOut != 0) begin errors++; $display("[TB] FAIL timeout_no_out: got %0d expected 0", sawOut); end
    checks++; if (winReady !== 1'b1) begin errors++; $display("[TB] FAIL timeout_idle: got %b expected 1", winReady); end
    modelEn = 1'b1;
  endtask

  task automatic test_reset_mid();
    applyStimulus(packWin(1, 0));
    repeat (5) @(negedge clk);
    checks++; if (pmData0 !== 8'd1 || pmWeight0 !== 8'd16) begin errors++; $display("[TB] FAIL midrst_row1_taps: got d0=%0d w0=%0d expected 1/16", pmData0, pmWeight0); end
    rstN = 1'b0;
    #1;
    checks++; if (winReady !== 1'b1 || outValid !== 1'b0 || pmUpdate !== 1'b0) begin errors++; $display("[TB] FAIL midrst_handshake: got ready=%b valid=%b update=%b expected 1/0/0", winReady, outValid, pmUpdate); end
    checks++; if (outData !== 8'd0) begin errors++; $display("[TB] FAIL midrst_out_data: got %0d expected 0", outData); end
    checks++; if (pmData0 !== 8'd0 || pmWeight0 !== 8'd0) begin errors++; $display("[TB] FAIL midrst_taps: got d0=%0d w0=%0d expected 0/0", pmData0, pmWeight0); end
    @(negedge clk);
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    writeAllWeights(8'd1);
    applyStimulus(packWin(1, 1));
    runToOut(1, 60);
    checks++; if (outCyc != 13) begin errors++; $display("[TB] FAIL midrst_out_cycle: got %0d expected 13", outCyc); end
    checks++; if (outData !== 8'd45) begin errors++; $display("[TB] FAIL midrst_out_data_after: got %0d expected 45", outData); end
    consumeOut();
  endtask

  initial begin
    $display("[TB] conv3x3_sched directed tests");
    test_reset();
    test_basic();
    test_wrap();
    test_back_to_back();
    test_dropped_writes();
    test_write_on_accept();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
